// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// Everything here is evaluated at elaboration time. Nothing in this package
// builds runtime logic.
//   prog_w    : width of the progress counter for a given pattern length
//   kmp_next  : KMP automaton transition for (state, bit)
//   kmp_fail  : longest proper prefix of the pattern that is also a suffix
package seq_det_pkg;

    localparam int unsigned MAX_PATTERN_W = 16;

    function automatic int unsigned prog_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    // Bit at position pos of the pattern, counted in arrival order (pos 0 = MSB).
    function automatic logic pat_bit(input logic [15:0] pattern, input int unsigned width,
                                     input int unsigned pos);
        logic [15:0] sh;
        sh = pattern >> (width - 1 - pos);
        return sh[0];
    endfunction

    // Longest pattern prefix that is a suffix of (matched prefix of length state, then b).
    function automatic int unsigned kmp_next(input logic [15:0] pattern, input int unsigned width,
                                             input int unsigned state, input logic b);
        int unsigned best;
        int unsigned j;
        logic        ok;
        logic        sb;
        best = 0;
        if (state >= width) return 0;
        for (int unsigned k = 1; k <= state + 1; k++) begin
            ok = 1'b1;
            for (int unsigned i = 0; i < k; i++) begin
                j  = state + 1 - k + i;
                sb = (j == state) ? b : pat_bit(pattern, width, j);
                if (pat_bit(pattern, width, i) != sb) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    // Restart point after a full match when overlapping detection is enabled.
    function automatic int unsigned kmp_fail(input logic [15:0] pattern, input int unsigned width);
        int unsigned best;
        logic        ok;
        best = 0;
        for (int unsigned k = 1; k < width; k++) begin
            ok = 1'b1;
            for (int unsigned i = 0; i < k; i++) begin
                if (pat_bit(pattern, width, i) != pat_bit(pattern, width, width - k + i)) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Serial source <-> detector bundle.
//   master (bit source): drives x, x_valid, overlap; observes out, match_count, progress
//   slave  (detector)  : the reverse
interface seq_pattern_detector_if #(
    parameter int unsigned PATTERN_W = 4,
    parameter int unsigned CNT_W     = 8
);
    import seq_det_pkg::*;

    localparam int unsigned PROG_W = prog_w(PATTERN_W);

    logic              x;
    logic              x_valid;
    logic              overlap;
    logic              out;
    logic [CNT_W-1:0]  match_count;
    logic [PROG_W-1:0] progress;

    modport master (output x, x_valid, overlap, input out, match_count, progress);
    modport slave  (input x, x_valid, overlap, output out, match_count, progress);

endinterface

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment enable.
//   clk   : rising-edge clock
//   clear : synchronous active-high clear (wins over inc)
//   inc   : add one unless already at all-ones
//   count : registered count value
module seq_det_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Parametrised serial bit-pattern detector (KMP automaton, Mealy-style match
// registered into a one-cycle pulse).
//   clk   : rising-edge clock
//   clear : synchronous active-high reset, priority over everything
//   bus   : slave side of seq_pattern_detector_if
//           x/x_valid serial input, overlap mode select,
//           out match pulse, match_count, progress (matched-prefix length)
// Optional feature: define SEQ_DET_MATCH_CNT_EN to build the match counter;
// otherwise match_count is tied to zero.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned          PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1001,
    parameter int unsigned          CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  clear,
    seq_pattern_detector_if.slave bus
);

    localparam int unsigned PROG_W = prog_w(PATTERN_W);
    localparam int unsigned DEPTH  = 2 ** PROG_W;
    localparam int unsigned FAIL_P = kmp_fail(16'(PATTERN), PATTERN_W);

    if ((PATTERN_W < 1) || (PATTERN_W > MAX_PATTERN_W)) begin : g_bad_width
        $error("seq_pattern_detector: PATTERN_W must be in 1..16");
    end

    // Constant transition table; rows past PATTERN_W-1 are unreachable and hold 0.
    logic [PROG_W-1:0] nxt_tbl [DEPTH][2];

    for (genvar s = 0; s < DEPTH; s++) begin : g_row
        for (genvar b = 0; b < 2; b++) begin : g_col
            localparam int unsigned N = kmp_next(16'(PATTERN), PATTERN_W, s, 1'(b));
            assign nxt_tbl[s][b] = PROG_W'(N);
        end
    end

    logic [PROG_W-1:0] p;
    logic              out_q;
    logic              last_bit;
    logic              hit;
    logic [PROG_W-1:0] p_nxt;

    // A completing sample: last pattern position reached and the final bit matches.
    assign last_bit = (p == PROG_W'(PATTERN_W - 1));
    assign hit      = bus.x_valid && last_bit && (bus.x == PATTERN[0]);
    assign p_nxt    = hit ? (bus.overlap ? PROG_W'(FAIL_P) : '0) : nxt_tbl[p][bus.x];

    // Progress state and registered match pulse.
    always_ff @(posedge clk) begin
        if (clear) begin
            p     <= '0;
            out_q <= 1'b0;
        end else begin
            out_q <= hit;
            if (bus.x_valid) begin
                p <= p_nxt;
            end
        end
    end

    assign bus.out      = out_q;
    assign bus.progress = p;

`ifdef SEQ_DET_MATCH_CNT_EN
    seq_det_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .clear (clear),
        .inc   (hit),
        .count (bus.match_count)
    );
`else
    assign bus.match_count = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed self-checking bench for seq_pattern_detector.
//   d0 : PATTERN=1001, CNT_W=8
//   d1 : PATTERN=111,  CNT_W=8
//   d2 : PATTERN=1001, CNT_W=2 (counter saturation)
module tb_seq_pattern_detector;

    logic clk = 1'b0;
    logic clear = 1'b0;
    logic x = 1'b0;
    logic xv = 1'b0;
    logic ov = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_pattern_detector_if #(.PATTERN_W(4), .CNT_W(8)) if0 ();
    seq_pattern_detector_if #(.PATTERN_W(3), .CNT_W(8)) if1 ();
    seq_pattern_detector_if #(.PATTERN_W(4), .CNT_W(2)) if2 ();

    assign if0.x = x;  assign if0.x_valid = xv;  assign if0.overlap = ov;
    assign if1.x = x;  assign if1.x_valid = xv;  assign if1.overlap = ov;
    assign if2.x = x;  assign if2.x_valid = xv;  assign if2.overlap = ov;

    seq_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1001), .CNT_W(8)) d0 (
        .clk(clk), .clear(clear), .bus(if0.slave));
    seq_pattern_detector #(.PATTERN_W(3), .PATTERN(3'b111), .CNT_W(8)) d1 (
        .clk(clk), .clear(clear), .bus(if1.slave));
    seq_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1001), .CNT_W(2)) d2 (
        .clk(clk), .clear(clear), .bus(if2.slave));

    function automatic int exp_cnt(input int n, input int maxv);
`ifdef SEQ_DET_MATCH_CNT_EN
        return (n > maxv) ? maxv : n;
`else
        return 0 * (n + maxv);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Apply one sample, clock it in, and settle just after the edge.
    task automatic step(input logic c, input logic xb, input logic vb);
        clear = c;
        x     = xb;
        xv    = vb;
        @(posedge clk);
        #1;
    endtask

    logic s_x   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic o_ov  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int   p_ov  [7] = '{1, 2, 3, 1, 2, 3, 1};
    logic o_nov [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int   p_nov [7] = '{1, 2, 3, 0, 0, 0, 1};
    // gapped stream: x, x_valid, expected out, expected progress
    logic g_x   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic g_v   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic g_o   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int   g_p   [7] = '{1, 2, 2, 2, 2, 3, 1};
    logic b_o1  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int   b_p1  [5] = '{1, 2, 2, 2, 2};
    logic b_o0  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int   b_p0  [5] = '{1, 2, 0, 1, 2};

    initial begin
        // Reset state
        ov = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        chk("rst_d0_out", 32'(if0.out), 0);
        chk("rst_d0_prog", 32'(if0.progress), 0);
        chk("rst_d0_cnt", 32'(if0.match_count), 0);
        chk("rst_d1_out", 32'(if1.out), 0);
        chk("rst_d1_prog", 32'(if1.progress), 0);
        chk("rst_d2_cnt", 32'(if2.match_count), 0);

        // Overlap mode, 1001 stream
        for (int i = 0; i < 7; i++) begin
            step(1'b0, s_x[i], 1'b1);
            chk($sformatf("ov_out_b%0d", i + 1), 32'(if0.out), 32'(o_ov[i]));
            chk($sformatf("ov_prog_b%0d", i + 1), 32'(if0.progress), 32'(p_ov[i]));
        end
        chk("ov_cnt", 32'(if0.match_count), 32'(exp_cnt(2, 255)));
        step(1'b0, 1'b0, 1'b0);
        chk("ov_pulse_end", 32'(if0.out), 0);

        // Non-overlap mode, same stream
        ov = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, s_x[i], 1'b1);
            chk($sformatf("nov_out_b%0d", i + 1), 32'(if0.out), 32'(o_nov[i]));
            chk($sformatf("nov_prog_b%0d", i + 1), 32'(if0.progress), 32'(p_nov[i]));
        end
        chk("nov_cnt", 32'(if0.match_count), 32'(exp_cnt(1, 255)));

        // Gapped samples
        ov = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, g_x[i], g_v[i]);
            chk($sformatf("gap_out_s%0d", i), 32'(if0.out), 32'(g_o[i]));
            chk($sformatf("gap_prog_s%0d", i), 32'(if0.progress), 32'(g_p[i]));
        end
        chk("gap_cnt", 32'(if0.match_count), 32'(exp_cnt(1, 255)));

        // Clear mid-sequence discards the partial match
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("mid_prog_pre", 32'(if0.progress), 3);
        step(1'b1, 1'b1, 1'b1);
        chk("mid_clr_out", 32'(if0.out), 0);
        chk("mid_clr_prog", 32'(if0.progress), 0);
        step(1'b0, 1'b1, 1'b1);
        chk("mid_after_out", 32'(if0.out), 0);
        chk("mid_after_prog", 32'(if0.progress), 1);
        chk("mid_cnt", 32'(if0.match_count), 0);

        // Back-to-back on 111, overlap then non-overlap
        ov = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk($sformatf("b2b_ov_out_b%0d", i + 1), 32'(if1.out), 32'(b_o1[i]));
            chk($sformatf("b2b_ov_prog_b%0d", i + 1), 32'(if1.progress), 32'(b_p1[i]));
        end
        chk("b2b_ov_cnt", 32'(if1.match_count), 32'(exp_cnt(3, 255)));
        ov = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk($sformatf("b2b_nov_out_b%0d", i + 1), 32'(if1.out), 32'(b_o0[i]));
            chk($sformatf("b2b_nov_prog_b%0d", i + 1), 32'(if1.progress), 32'(b_p0[i]));
        end
        chk("b2b_nov_cnt", 32'(if1.match_count), 32'(exp_cnt(1, 255)));

        // Five overlapping 1001 matches: d2 counter saturates at 3
        ov = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        for (int m = 0; m < 5; m++) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b1, 1'b1);
            chk($sformatf("sat_out_m%0d", m + 1), 32'(if2.out), 1);
            chk($sformatf("sat_cnt_m%0d", m + 1), 32'(if2.match_count), 32'(exp_cnt(m + 1, 3)));
        end
        chk("sat_d0_cnt", 32'(if0.match_count), 32'(exp_cnt(5, 255)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
Name: seq_pattern_detector

Overview:
- Parametrised serial bit-pattern detector; next generation of the fixed-pattern Mealy sequence detectors in the FSM library.
- Pattern value and length are parameters; overlap/non-overlap mode is a runtime input; a sample-valid qualifier is added.
- A match counter is available as an optional feature.
- Sits behind any serial bit source; out is a registered single-cycle match pulse.

Parameters:
- PATTERN_W, 4, pattern length in bits; legal range 1..16.
- PATTERN, 4'b1001, target pattern; MSB is the first bit received.
- CNT_W, 8, width of match_count.

Ports:
- clk  input  1  rising-edge clock; only clock.
- clear  input  1  synchronous, active-high reset.
- x  input  1  serial data bit.
- x_valid  input  1  x sampled only when high.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- out  output  1  registered match pulse.
- match_count  output  CNT_W  saturating number of matches.
- progress  output  $clog2(PATTERN_W+1)  current matched-prefix length (debug).

Behaviour:
- Reset:
  - clear is sampled at the clk edge only (synchronous, active-high).
  - On clear: progress=0, out=0, match_count=0.
  - clear has priority over every other input, including mid-sequence; the partial match is discarded.
- State: progress p in 0..PATTERN_W-1 is the number of pattern bits currently matched. The expected next bit is PATTERN[PATTERN_W-1-p].
- x_valid=0: p, match_count and the mode all hold; out=0 next cycle.
- x_valid=1, bit does not complete the pattern:
  - p_next = KMP automaton transition delta(p, x).
  - delta = longest prefix of PATTERN that is a suffix of (matched prefix followed by x).
  - The fallback is exact, so no valid prefix is ever lost (e.g. 1001: p=1, x=1 -> p=1).
- x_valid=1, bit completes the pattern (p=PATTERN_W-1 and x matches):
  - out=1 in the next cycle.
  - p_next = F when overlap=1, where F = longest proper prefix of PATTERN that is also a suffix of PATTERN.
  - p_next = 0 when overlap=0.
- Output timing:
  - Latency is 1 clk from the completing sample edge to out high.
  - out is high for exactly one cycle per match.
  - Back-to-back pulses are legal (e.g. all-ones pattern with overlap=1).
- overlap is sampled only on the completing edge. Changing it mid-sequence never alters the current progress.
- PATTERN_W=1 case: p is always 0; out = registered (x_valid & x==PATTERN[0]); overlap has no effect.
- match_count:
  - Increments by 1 on each completing edge.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by clear.
- Transition table and F are constants computed at elaboration; there is no runtime table logic.
- Parameter check: PATTERN_W outside 1..16 is an elaboration-time error.

Optional Feature:
- Macro: SEQ_DET_MATCH_CNT_EN.
- Defined: match_count behaves as above.
- Undefined: counter logic is not built; match_count is tied to 0; all other behaviour is identical.

Decomposition:
- Package seq_det_pkg holds:
  - constant function kmp_next(pattern, width, state, bit) returning the automaton next state;
  - constant function kmp_fail(pattern, width) returning F;
  - PROG_W helper, equal to $clog2(PATTERN_W+1).
- One natural sub-module: seq_det_sat_cnt, a CNT_W saturating counter with sync clear and increment enable, instantiated under the macro.

Test Plan:
- Overlap mode, default PATTERN=1001, overlap=1: x_valid=1, x stream 1,0,0,1,0,0,1 after clear -> out pulses the cycle after bits 4 and 7; match_count=2.
- Non-overlap mode, same stream with overlap=0 -> single pulse after bit 4; final progress=1; match_count=1.
- Gapped samples: stream 1,0,(x_valid=0 for 3 cycles, x toggling),0,1 -> one pulse after the final 1; no pulse during the gap.
- Reset mid-sequence: bits 1,0,0 then clear=1 for one edge, then 1 -> no pulse; progress=1 after the 1.
- Back-to-back matches: PATTERN_W=3, PATTERN=111, overlap=1, five 1s -> out high for three consecutive cycles after bits 3, 4, 5. Same stimulus with overlap=0 -> only one pulse, after bit 3.
- Counter saturation and macro off:
  - With SEQ_DET_MATCH_CNT_EN defined and CNT_W=2: five matches -> match_count stops at 3.
  - With the macro undefined: match_count stays 0 throughout.
